// File: rtl/softmax_pkg.sv
// Q5.11 constants, sequencer state encoding and the shared saturation helper for the softmax normaliser.
package softmax_pkg;

   localparam int INT_BIT  = 5;
   localparam int FRAC_BIT = 11;
   localparam int QW       = INT_BIT + FRAC_BIT;

   localparam logic [QW-1:0] Q_ONE = 16'h0800;
   localparam logic [QW-1:0] Q_MAX = 16'h7FFF;
   localparam logic [QW-1:0] Q_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RECIP,
      DRAIN
   } state_t;

   // Clamp a double-width signed value into the QW-bit signed range.
   function automatic logic [QW-1:0] q_sat(input logic signed [2*QW-1:0] v);
      logic [QW-1:0] r;
      if (!v[2*QW-1] && (|v[2*QW-2:QW-1])) begin
         r = Q_MAX;
      end else if (v[2*QW-1] && !(&v[2*QW-2:QW-1])) begin
         r = Q_MIN;
      end else begin
         r = v[QW-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/softmax_normalize_buf.sv
// Element store for one softmax vector: DEPTH x DWIDTH registers, one write port, one asynchronous read port.
// Contents are not reset; every location is rewritten before it is read back.
module softmax_normalize_buf #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DWIDTH-1:0] wr_dat,
   input  logic [AW-1:0]     rd_addr,
   output logic [DWIDTH-1:0] rd_dat
);

   logic [DWIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/softmax_normalize.sv
// Softmax normaliser: buffers Q5.11 exp() values, obtains 1/sum from the reciprocal unit, streams exp[i]*(1/sum).
// Latency: i_last accept -> RECIP 1 cycle, reciprocal capture -> first o_valid 2 cycles, then 1 element/cycle.
// Backpressure: o_ready only in IDLE/LOAD; o_data held while o_valid && !i_ready. SOFTMAX_ROUND_EN selects round-half-up.
module softmax_normalize #(
   parameter int INT_BIT  = softmax_pkg::INT_BIT,
   parameter int FRAC_BIT = softmax_pkg::FRAC_BIT,
   parameter int DWIDTH   = INT_BIT + FRAC_BIT,
   parameter int CNT_BIT  = 16,
   parameter int DEPTH    = 64,
   parameter int TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               i_valid,
   input  logic               i_last,
   input  logic [DWIDTH-1:0]  i_data,
   output logic               o_ready,
   output logic               o_recip_en,
   output logic [DWIDTH-1:0]  o_recip_in,
   output logic [CNT_BIT-1:0] o_recip_num,
   input  logic [DWIDTH-1:0]  i_recip_out,
   input  logic               i_recip_valid,
   output logic               o_valid,
   output logic [DWIDTH-1:0]  o_data,
   output logic               o_last,
   input  logic               i_ready,
   output logic               o_ovf,
   output logic               o_err
);
   import softmax_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = DWIDTH + AW;
   localparam int PW = 2 * DWIDTH;
   localparam int TW = $clog2(TIMEOUT + 2);

   state_t             state_q, state_d;
   logic [SW-1:0]      sum_q, sum_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      rd_q, rd_d;
   logic [TW-1:0]      wait_q, wait_d;
   logic [DWIDTH-1:0]  recip_q, recip_d;
   logic [DWIDTH-1:0]  recip_in_q, recip_in_d;
   logic [CNT_BIT-1:0] recip_num_q, recip_num_d;
   logic [DWIDTH-1:0]  data_q, data_d;
   logic               ready_q, ready_d;
   logic               recip_en_q, recip_en_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;

   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [DWIDTH-1:0]  rd_dat;
   logic [SW-1:0]      din_ext;
   logic               acc, fire, adv;
   logic signed [PW-1:0] prod, prod_r;

   softmax_normalize_buf #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_dat  (i_data),
      .rd_addr (rd_q[AW-1:0]),
      .rd_dat  (rd_dat)
   );

   always_comb begin
      acc     = ready_q && i_valid;
      fire    = valid_q && i_ready;
      adv     = !valid_q || i_ready;
      din_ext = {{AW{1'b0}}, i_data};
      prod    = $signed(rd_dat) * $signed(recip_q);
`ifdef SOFTMAX_ROUND_EN
      prod_r  = prod + (PW'(1) <<< (FRAC_BIT - 1));
`else
      prod_r  = prod;
`endif

      state_d     = state_q;
      sum_d       = sum_q;
      count_d     = count_q;
      rd_d        = rd_q;
      wait_d      = wait_q;
      recip_d     = recip_q;
      recip_in_d  = recip_in_q;
      recip_num_d = recip_num_q;
      data_d      = data_q;
      recip_en_d  = recip_en_q;
      valid_d     = valid_q;
      last_d      = last_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      wr_en       = 1'b0;
      wr_addr     = count_q[AW-1:0];

      case (state_q)
         IDLE: begin
            if (acc) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               sum_d   = din_ext;
               count_d = CW'(1);
               ovf_d   = 1'b0;
               err_d   = 1'b0;
               wait_d  = '0;
               state_d = i_last ? RECIP : LOAD;
            end
         end
         LOAD: begin
            if (acc) begin
               sum_d = sum_q + din_ext;
               // Beyond DEPTH the element still counts toward the sum but is not stored.
               if (count_q < CW'(DEPTH)) begin
                  wr_en   = 1'b1;
                  count_d = count_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
               if (i_last) begin
                  wait_d  = '0;
                  state_d = RECIP;
               end
            end
         end
         RECIP: begin
            wait_d = wait_q + 1'b1;
            rd_d   = '0;
            if (sum_q == '0) begin
               recip_d = '0;
               state_d = DRAIN;
            end else if (recip_en_q && i_recip_valid) begin
               recip_d    = i_recip_out;
               recip_en_d = 1'b0;
               state_d    = DRAIN;
            end else if (wait_q > TW'(TIMEOUT)) begin
               recip_d    = Q_MAX;
               err_d      = 1'b1;
               recip_en_d = 1'b0;
               state_d    = DRAIN;
            end else begin
               recip_en_d = 1'b1;
            end
         end
         DRAIN: begin
            if (adv && (rd_q < count_q)) begin
               valid_d = 1'b1;
               data_d  = q_sat(prod_r >>> FRAC_BIT);
               last_d  = (rd_q == count_q - 1'b1);
               rd_d    = rd_q + 1'b1;
            end else if (fire) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               data_d  = '0;
            end
            if (fire && last_q) begin
               rd_d    = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reciprocal operands are latched once on RECIP entry so they stay stable for the whole handshake.
      if ((state_d == RECIP) && (state_q != RECIP)) begin
         recip_in_d  = q_sat($signed({{(PW-SW){1'b0}}, sum_d}));
         recip_num_d = {{(CNT_BIT-CW){1'b0}}, count_d - 1'b1};
      end

      ready_d = (state_d == IDLE) || (state_d == LOAD);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         count_q     <= '0;
         rd_q        <= '0;
         wait_q      <= '0;
         recip_q     <= '0;
         recip_in_q  <= '0;
         recip_num_q <= '0;
         data_q      <= '0;
         ready_q     <= 1'b0;
         recip_en_q  <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         rd_q        <= rd_d;
         wait_q      <= wait_d;
         recip_q     <= recip_d;
         recip_in_q  <= recip_in_d;
         recip_num_q <= recip_num_d;
         data_q      <= data_d;
         ready_q     <= ready_d;
         recip_en_q  <= recip_en_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
      end
   end

   assign o_ready     = ready_q;
   assign o_recip_en  = recip_en_q;
   assign o_recip_in  = recip_in_q;
   assign o_recip_num = recip_num_q;
   assign o_valid     = valid_q;
   assign o_data      = data_q;
   assign o_last      = last_q;
   assign o_ovf       = ovf_q;
   assign o_err       = err_q;

endmodule
